// File: rtl/modsum_reduce_pipe.sv
// Pipelined modular accumulator: registered adder tree over NUM_TERMS residues, then one-stage reduction.
// Optional input range check enabled by defining MODSUM_INPUT_CHECK_EN (sticky err_out).
module modsum_reduce_pipe #(
    parameter int unsigned MODULUS     = 65521,
    parameter int unsigned MODBITWIDTH = 16,
    parameter int unsigned NUM_TERMS   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_TERMS*MODBITWIDTH-1:0] terms_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MODBITWIDTH-1:0]           value_out,
    output logic                             err_out
);

    localparam int unsigned LEVELS = $clog2(NUM_TERMS);
    localparam int unsigned SW     = MODBITWIDTH + LEVELS;

    function automatic int unsigned lvl_cnt(input int unsigned l);
        return (NUM_TERMS + (32'd1 << l) - 32'd1) >> l;
    endfunction

    function automatic int unsigned lvl_off(input int unsigned l);
        int unsigned o;
        o = 0;
        for (int unsigned i = 0; i < l; i++) o += lvl_cnt(i);
        return o;
    endfunction

    function automatic logic [SW:0] kmod(input int unsigned k);
        return (SW+1)'(64'(k) * 64'(MODULUS));
    endfunction

    // Table covers sums of unreduced terms, so the result stays < MODULUS for any input.
    localparam longint unsigned SUM_BOUND = 64'(NUM_TERMS) << MODBITWIDTH;
    localparam int unsigned KMAX  = int'((SUM_BOUND + 64'(MODULUS) - 64'd1) / 64'(MODULUS));
    localparam int unsigned NODES = lvl_off(LEVELS + 1);
    localparam int unsigned ROOT  = NODES - 1;

    logic [SW-1:0]          node_q [NODES];
    logic [SW-1:0]          node_d [NODES];
    logic [LEVELS:0]        vld_q, vld_d;
    logic                   out_valid_q, out_valid_d;
    logic [MODBITWIDTH-1:0] value_q, value_d;
    logic [SW:0]            sum_ext;
    logic                   stall;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign value_out = value_q;

    // All tree levels live in one flat node array; level l starts at lvl_off(l).
    always_comb begin
        for (int unsigned i = 0; i < NODES; i++) node_d[i] = '0;
        for (int unsigned k = 0; k < NUM_TERMS; k++) begin
            node_d[k] = in_valid ? SW'(terms_in[k*MODBITWIDTH +: MODBITWIDTH]) : '0;
        end
        for (int unsigned l = 1; l <= LEVELS; l++) begin
            for (int unsigned j = 0; j < lvl_cnt(l); j++) begin
                if (2*j + 1 < lvl_cnt(l - 1)) begin
                    node_d[lvl_off(l) + j] = node_q[lvl_off(l - 1) + 2*j]
                                           + node_q[lvl_off(l - 1) + 2*j + 1];
                end else begin
                    node_d[lvl_off(l) + j] = node_q[lvl_off(l - 1) + 2*j];
                end
            end
        end
        vld_d       = {vld_q[LEVELS-1:0], in_valid};
        out_valid_d = vld_q[LEVELS];
    end

    assign sum_ext = {1'b0, node_q[ROOT]};

    always_comb begin
        value_d = sum_ext[MODBITWIDTH-1:0];
        for (int unsigned k = 1; k <= KMAX; k++) begin
            if (sum_ext >= kmod(k)) value_d = MODBITWIDTH'(sum_ext - kmod(k));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NODES; i++) node_q[i] <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            value_q     <= '0;
        end else if (!stall) begin
            node_q      <= node_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            value_q     <= value_d;
        end
    end

`ifdef MODSUM_INPUT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (in_valid && in_ready) begin
            for (int unsigned k = 0; k < NUM_TERMS; k++) begin
                if ({1'b0, terms_in[k*MODBITWIDTH +: MODBITWIDTH]} >= (MODBITWIDTH+1)'(MODULUS))
                    err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_modsum_reduce_pipe.sv
// Self-checking bench for modsum_reduce_pipe: directed cases plus randomized traffic vs a sum-mod model.
module tb_modsum_reduce_pipe;

    localparam int unsigned M = 65521;
    localparam int unsigned W = 16;
    localparam int unsigned N = 8;
`ifdef MODSUM_INPUT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, out_valid, out_ready, err_out;
    logic [N*W-1:0] terms_in;
    logic [W-1:0]   value_out;

    logic           in_valid5, in_ready5, out_valid5, out_ready5, err5;
    logic [5*W-1:0] terms5;
    logic [W-1:0]   value5;

    int unsigned tv [N];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    modsum_reduce_pipe #(.MODULUS(M), .MODBITWIDTH(W), .NUM_TERMS(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .terms_in(terms_in), .out_valid(out_valid), .out_ready(out_ready),
        .value_out(value_out), .err_out(err_out)
    );

    modsum_reduce_pipe #(.MODULUS(M), .MODBITWIDTH(W), .NUM_TERMS(5)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
        .terms_in(terms5), .out_valid(out_valid5), .out_ready(out_ready5),
        .value_out(value5), .err_out(err5)
    );

    function automatic int unsigned model_mod(input int unsigned n);
        longint unsigned s;
        s = 0;
        for (int unsigned i = 0; i < n; i++) s += longint'(tv[i]);
        return int'(s % longint'(M));
    endfunction

    task automatic pack_terms();
        for (int unsigned i = 0; i < N; i++) terms_in[i*W +: W] = W'(tv[i]);
    endtask

    task automatic set_all(input int unsigned v);
        for (int unsigned i = 0; i < N; i++) tv[i] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
    endtask

    // Sends the beat held in tv and reports latency, result and err_out one edge after accept.
    task automatic run_single(output int lat, output logic [W-1:0] val, output logic err1);
        pack_terms();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        err1 = err_out;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        val = value_out;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_valid5 = 1'b0; out_ready5 = 1'b1; terms5 = '0;
        set_all(0); pack_terms();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (value_out !== '0) begin bad++; $display("FAIL reset_value: got %0d expected 0", value_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err_out); end
        @(negedge clk) reset = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_latency();
        int lat; logic [W-1:0] val; logic e1;
        drain();
        set_all(M - 1);
        run_single(lat, val, e1);
        total++; if (lat != 5) begin bad++; $display("FAIL latency: got %0d expected 5", lat); end
        total++; if (val !== W'(model_mod(N))) begin bad++; $display("FAIL max_terms_value: got %0d expected %0d", val, model_mod(N)); end
        total++; if (e1 !== 1'b0) begin bad++; $display("FAIL max_terms_err: got %b expected 0", e1); end
    endtask

    task automatic test_patterns();
        int lat; logic [W-1:0] val; logic e1;
        for (int p = 0; p < 8; p++) begin
            set_all(0);
            case (p)
                0: begin tv[0] = M - 1; tv[1] = 1; end
                1: ;
                2: tv[3] = 12345;
                default: for (int unsigned i = 0; i < N; i++) tv[i] = $urandom_range(0, M - 1);
            endcase
            drain();
            run_single(lat, val, e1);
            total++; if (val !== W'(model_mod(N))) begin bad++; $display("FAIL pattern%0d_value: got %0d expected %0d", p, val, model_mod(N)); end
            total++; if (lat != 5) begin bad++; $display("FAIL pattern%0d_latency: got %0d expected 5", p, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int sent, got;
        logic [W-1:0] hold_val;
        drain();
        sent = 0; got = 0; hold_val = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            out_ready = !(cyc >= 7 && cyc <= 9);
            in_valid  = (sent < 10);
            set_all(sent); pack_terms();
            #1;
            if (cyc >= 7 && cyc <= 9) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready: got %b expected 0 at cycle %0d", in_ready, cyc); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_stall_valid: got %b expected 1 at cycle %0d", out_valid, cyc); end
                if (cyc == 7) hold_val = value_out;
                else begin
                    total++; if (value_out !== hold_val) begin bad++; $display("FAIL b2b_hold: got %0d expected %0d", value_out, hold_val); end
                end
            end
            if (out_valid && out_ready) begin
                total++; if (value_out !== W'((N * got) % M)) begin bad++; $display("FAIL b2b_order: got %0d expected %0d", value_out, (N * got) % M); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        total++; if (got != 10) begin bad++; $display("FAIL b2b_count: got %0d expected 10", got); end
        drain();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat, stale; logic [W-1:0] val; logic e1;
        drain();
        for (int i = 0; i < 5; i++) begin
            set_all(100 + i); pack_terms();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_valid: got %b expected 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        total++; if (value_out !== '0) begin bad++; $display("FAIL rst_mid_value: got %0d expected 0", value_out); end
        tick();
        reset = 1'b0;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL rst_mid_stale: got %0d expected 0", stale); end
        set_all(7);
        run_single(lat, val, e1);
        total++; if (lat != 5) begin bad++; $display("FAIL rst_mid_latency: got %0d expected 5", lat); end
        total++; if (val !== W'(model_mod(N))) begin bad++; $display("FAIL rst_mid_value_after: got %0d expected %0d", val, model_mod(N)); end
    endtask

    task automatic test_err();
        int lat; logic [W-1:0] val; logic e1;
        drain();
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL err_initial: got %b expected 0", err_out); end
        set_all(0); tv[5] = M;
        run_single(lat, val, e1);
        total++; if (e1 !== EXP_ERR) begin bad++; $display("FAIL err_set: got %b expected %b", e1, EXP_ERR); end
        total++; if (val !== W'(model_mod(N))) begin bad++; $display("FAIL err_value: got %0d expected %0d", val, model_mod(N)); end
        set_all(3);
        run_single(lat, val, e1);
        total++; if (e1 !== EXP_ERR) begin bad++; $display("FAIL err_sticky: got %b expected %b", e1, EXP_ERR); end
        total++; if (val !== W'(model_mod(N))) begin bad++; $display("FAIL err_clean_value: got %0d expected %0d", val, model_mod(N)); end
    endtask

    task automatic test_random();
        int unsigned expq[$];
        int unsigned exp;
        int unsigned r;
        logic prev_stall;
        logic [W-1:0] prev_val;
        drain();
        prev_stall = 1'b0; prev_val = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            for (int unsigned i = 0; i < N; i++) begin
                r = $urandom % 8;
                tv[i] = (r == 0) ? M - 1 : (r == 1) ? 32'hFFFF : (r == 2) ? 0 : $urandom % 65536;
            end
            pack_terms();
            #1;
            if (prev_stall) begin
                total++; if ({out_valid, value_out} !== {1'b1, prev_val}) begin bad++; $display("FAIL rand_hold: got %b/%0d expected 1/%0d", out_valid, value_out, prev_val); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin bad++; $display("FAIL rand_extra: got %0d expected no output", value_out); end
                else begin
                    exp = expq.pop_front();
                    if (value_out !== W'(exp)) begin bad++; $display("FAIL rand_value: got %0d expected %0d", value_out, exp); end
                end
            end
            if (in_valid && in_ready) expq.push_back(model_mod(N));
            prev_stall = out_valid && !out_ready;
            prev_val   = value_out;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 30 && expq.size() != 0; c++) begin
            if (out_valid) begin
                exp = expq.pop_front();
                total++; if (value_out !== W'(exp)) begin bad++; $display("FAIL rand_drain_value: got %0d expected %0d", value_out, exp); end
            end
            tick();
        end
        total++; if (expq.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d pending expected 0", expq.size()); end
    endtask

    task automatic test_n5();
        int lat;
        set_all(0);
        for (int unsigned i = 0; i < 5; i++) begin
            tv[i] = M - 1;
            terms5[i*W +: W] = W'(M - 1);
        end
        in_valid5 = 1'b1; out_ready5 = 1'b1;
        tick();
        in_valid5 = 1'b0;
        lat = 1;
        while (!out_valid5 && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (lat != 5) begin bad++; $display("FAIL n5_latency: got %0d expected 5", lat); end
        total++; if (value5 !== W'(model_mod(5))) begin bad++; $display("FAIL n5_value: got %0d expected %0d", value5, model_mod(5)); end
        total++; if (err5 !== 1'b0) begin bad++; $display("FAIL n5_err: got %b expected 0", err5); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_err();
        test_random();
        test_n5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modsum_reduce_pipe.md
Name: modsum_reduce_pipe

Overview:
- Pipelined modular accumulator directly downstream of the LUT6 modulo-residue stage.
- Consumes NUM_TERMS partial residues per beat, each already < MODULUS. Each term is one LUT6 group output or the unreduced low word.
- Sums them through a registered adder tree, then fully reduces the sum to [0, MODULUS).
- Feeds the next square/multiply iteration through a valid/ready handshake.

Parameters:
- MODULUS, 65521, modulus value; must be < 2**MODBITWIDTH.
- MODBITWIDTH, 16, width of each term and of the result.
- NUM_TERMS, 8, residues summed per beat; integer >= 2, not required to be a power of two.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  terms_in holds a beat.
- in_ready  output  1  stage accepts a beat this cycle.
- terms_in  input  NUM_TERMS*MODBITWIDTH  packed terms; term k = bits [k*MODBITWIDTH +: MODBITWIDTH].
- out_valid  output  1  value_out holds a result.
- out_ready  input  1  consumer accepts the result.
- value_out  output  MODBITWIDTH  (sum of terms) mod MODULUS.
- err_out  output  1  sticky input-range error (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high. While asserted and on release:
  - out_valid=0, value_out=0, err_out=0.
  - All internal valid bits and data registers = 0.
  - in_ready=1 from the first cycle after release.
- Defines: LEVELS = ceil(log2(NUM_TERMS)); SW = MODBITWIDTH + LEVELS (sum width; no overflow possible).
- Pipeline stages, each a register with its own valid bit:
  - S0: input capture.
  - S1..S_LEVELS: one adder-tree level each; pairwise add, odd leftover passes through zero-extended.
  - SR: final reduction.
- Latency = LEVELS + 2 cycles from accepted beat to out_valid. Default config = 5.
- Throughput: one beat per cycle while unstalled.
- Global stall:
  - stall = out_valid & ~out_ready.
  - When stall=1, every pipeline register and valid bit holds.
  - in_ready = ~stall, combinational.
- Accept: the beat is captured when in_valid & in_ready.
- Bubbles: in_valid=0 while unstalled inserts a bubble (valid bit 0) that advances normally.
- Final reduction, in one stage:
  - Input sum S < NUM_TERMS*MODULUS.
  - Compute all products k*MODULUS for k = 1..NUM_TERMS-1 as elaboration-time constants.
  - Pick the largest k with k*MODULUS <= S via parallel comparators; output S - k*MODULUS (k=0 if none).
  - Result is always < MODULUS.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated under any out_ready pattern.
- Output stability: value_out holds while out_valid=1 and out_ready=0.
- Simultaneous events: out_ready=1 together with a full pipeline and in_valid=1 accepts the new beat and retires the oldest in the same cycle.
- Reset mid-operation: all in-flight beats are discarded; no out_valid until a new beat is accepted after release.
- Out-of-range terms (>= MODULUS): the arithmetic still yields the correct mathematical sum mod MODULUS, as long as each term < 2**MODBITWIDTH. The reduction bound then becomes NUM_TERMS*(2**MODBITWIDTH). Constant table k = 1..ceil(NUM_TERMS*2**MODBITWIDTH/MODULUS) is sized so the output is still < MODULUS.

Optional Feature:
- Macro: MODSUM_INPUT_CHECK_EN.
- Defined:
  - On each accepted beat, every term is compared against MODULUS.
  - If any term >= MODULUS, err_out is set on the next clock edge.
  - err_out is sticky until reset; data path is unaffected.
- Undefined:
  - No comparators are built; err_out is tied to 0.

Test Plan:
- Defaults (MODULUS=65521, MODBITWIDTH=16, NUM_TERMS=8).
- All eight terms = 65520, out_ready=1 -> value_out=65513 with out_valid on cycle 5 after accept; err_out=0.
- term0=65520, term1=1, others 0 -> value_out=0; all terms 0 -> value_out=0; term3=12345, others 0 -> 12345.
- Ten back-to-back beats, beat i: all terms = i; hold out_ready=0 for 3 cycles mid-stream:
  - expect in_ready=0 during the stall;
  - outputs (8*i) mod 65521 = 0,8,...,72 in order, no loss or duplication.
- Assert reset for 1 cycle with 4 beats in flight -> out_valid=0, value_out=0 immediately; no stale results after release; next beat returns correctly at latency 5.
- With MODSUM_INPUT_CHECK_EN: accept a beat with term5=65521, others 0:
  - err_out=1 next cycle and stays 1 across later clean beats;
  - value_out=0.
  - Without the macro, the same stimulus gives err_out=0, value_out=0.
- Elaborate NUM_TERMS=5 (LEVELS=3), all terms 65520 -> value_out=65516, latency 5.
